// File: rtl/sbox_arbiter.sv
// Round-robin N_REQ:1 arbiter for one S-box ROM port: grant and ROM request are same-cycle, the result returns ROM_LAT cycles later.
// There is no result backpressure; unserved requesters hold req. Define SBOX_ARB_LOCK_EN to enable burst locking.
module sbox_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
`ifdef SBOX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   lock,
`endif
    input  logic [8*N_REQ-1:0] addr,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rvalid,
    output logic [7:0]         rdata,
    output logic               rom_en,
    output logic [7:0]         rom_addr,
    input  logic [7:0]         rom_data
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef SBOX_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, ARB, LOCKED} state_t;
    logic [PW-1:0] lk_q, lk_d;
`else
    typedef enum logic [1:0] {IDLE, ARB} state_t;
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   gidx;
    logic            hit;
    logic            any_gnt;
    logic [N_REQ-1:0] gnt_c;
    logic [N_REQ-1:0] tag_q [ROM_LAT];
    logic [N_REQ-1:0] tag_d [ROM_LAT];
    int              idx;

    always_comb begin
        sel     = '0;
        hit     = 1'b0;
        idx     = 0;
        gnt_c   = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef SBOX_ARB_LOCK_EN
        lk_d    = lk_q;
`endif

        // First requester at or after the pointer, wrapping.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!hit && req[idx]) begin
                hit = 1'b1;
                sel = PW'(idx);
            end
        end

`ifdef SBOX_ARB_LOCK_EN
        if (state_q == LOCKED && req[lk_q] && lock[lk_q]) begin
            // Burst owner keeps the port; pointer already points past it.
            gnt_c[lk_q] = 1'b1;
            gidx        = lk_q;
            any_gnt     = 1'b1;
            state_d     = LOCKED;
        end else
`endif
        if (hit) begin
            gnt_c[sel] = 1'b1;
            gidx       = sel;
            any_gnt    = 1'b1;
            ptr_d      = PW'((int'(sel) + 1) % N_REQ);
            state_d    = ARB;
`ifdef SBOX_ARB_LOCK_EN
            if (lock[sel]) begin
                state_d = LOCKED;
                lk_d    = sel;
            end
`endif
        end else begin
            state_d = IDLE;
        end

        if (rst) begin
            gnt_c   = '0;
            any_gnt = 1'b0;
        end
    end

    assign gnt      = gnt_c;
    assign rom_en   = any_gnt;
    assign rom_addr = any_gnt ? addr[8*int'(gidx) +: 8] : 8'h00;

    always_comb begin
        tag_d[0] = gnt_c;
        for (int k = 1; k < ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
`ifdef SBOX_ARB_LOCK_EN
            lk_q    <= '0;
`endif
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef SBOX_ARB_LOCK_EN
            lk_q    <= lk_d;
`endif
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign rvalid = rst ? '0 : tag_q[ROM_LAT-1];
    assign rdata  = (|rvalid) ? rom_data : 8'h00;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter: a ROM_LAT=1 and a ROM_LAT=3 instance, each with a small S-box ROM model.
module tb_sbox_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req1, req3;
    logic [31:0] addr1, addr3;
    logic [3:0]  gnt1, gnt3, rvalid1, rvalid3;
    logic [7:0]  rdata1, rdata3, rom_addr1, rom_addr3;
    logic        rom_en1, rom_en3;
    logic [7:0]  rom_data1, rom_data3;
    logic [7:0]  s3_1, s3_2;
`ifdef SBOX_ARB_LOCK_EN
    logic [3:0]  lock1, lock3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] rr_addr [4];
    logic [7:0] rr_sbox [4];

    always #5 clk = ~clk;

    sbox_arbiter #(.N_REQ(4), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1),
`ifdef SBOX_ARB_LOCK_EN
        .lock(lock1),
`endif
        .addr(addr1), .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1)
    );

    sbox_arbiter #(.N_REQ(4), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3),
`ifdef SBOX_ARB_LOCK_EN
        .lock(lock3),
`endif
        .addr(addr3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
        .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3)
    );

    function automatic logic [7:0] sbox(input logic [7:0] a);
        case (a)
            8'h00:   sbox = 8'h63;
            8'h01:   sbox = 8'h7C;
            8'h02:   sbox = 8'h77;
            8'h53:   sbox = 8'hED;
            default: sbox = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data1 <= rom_en1 ? sbox(rom_addr1) : 8'h00;
        s3_1      <= rom_en3 ? sbox(rom_addr3) : 8'h00;
        s3_2      <= s3_1;
        rom_data3 <= s3_2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rr_addr[0] = 8'h00; rr_addr[1] = 8'h01; rr_addr[2] = 8'h02; rr_addr[3] = 8'h53;
        rr_sbox[0] = 8'h63; rr_sbox[1] = 8'h7C; rr_sbox[2] = 8'h77; rr_sbox[3] = 8'hED;
        rst = 1'b1; req1 = '0; req3 = '0; addr1 = '0; addr3 = '0;
`ifdef SBOX_ARB_LOCK_EN
        lock1 = '0; lock3 = '0;
`endif

        // Reset holds every output low even with requests pending.
        tick();
        req1 = 4'b1111;
        #1;
        chk("rst_gnt",      32'(gnt1),      32'h0);
        chk("rst_rom_en",   32'(rom_en1),   32'h0);
        chk("rst_rom_addr", 32'(rom_addr1), 32'h0);
        chk("rst_rvalid",   32'(rvalid1),   32'h0);
        chk("rst_rdata",    32'(rdata1),    32'h0);
        req1 = '0;
        tick();
        rst = 1'b0;

        // Single lookup of 0x53 from requester 0.
        req1 = 4'b0001; addr1[7:0] = 8'h53;
        #1;
        chk("one_gnt",      32'(gnt1),      32'h1);
        chk("one_rom_en",   32'(rom_en1),   32'h1);
        chk("one_rom_addr", 32'(rom_addr1), 32'h53);
        tick();
        req1 = '0;
        #1;
        chk("one_rvalid",   32'(rvalid1),   32'h1);
        chk("one_rdata",    32'(rdata1),    32'hED);
        chk("idle_gnt",     32'(gnt1),      32'h0);
        chk("idle_rom_en",  32'(rom_en1),   32'h0);
        chk("idle_rom_addr",32'(rom_addr1), 32'h0);

        // Round robin with all four requesting, from a fresh reset.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req1  = 4'b1111;
        addr1 = {rr_addr[3], rr_addr[2], rr_addr[1], rr_addr[0]};
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt",      32'(gnt1),      32'(4'b0001 << (k % 4)));
            chk("rr_rom_addr", 32'(rom_addr1), 32'(rr_addr[k % 4]));
            if (k > 0) begin
                chk("rr_rvalid", 32'(rvalid1), 32'(4'b0001 << ((k - 1) % 4)));
                chk("rr_rdata",  32'(rdata1),  32'(rr_sbox[(k - 1) % 4]));
            end
            tick();
        end
        req1 = '0;
        #1;
        chk("rr_last_rvalid", 32'(rvalid1), 32'h8);
        chk("rr_last_rdata",  32'(rdata1),  32'hED);
        chk("rr_end_gnt",     32'(gnt1),    32'h0);

        // ROM_LAT=3: three back-to-back lookups by requester 2.
        req3 = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            addr3[23:16] = rr_addr[k];
            #1;
            chk("lat3_gnt",      32'(gnt3),      32'h4);
            chk("lat3_rom_addr", 32'(rom_addr3), 32'(rr_addr[k]));
            if (k > 0) chk("lat3_early_rvalid", 32'(rvalid3), 32'h0);
            tick();
        end
        req3 = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lat3_rvalid", 32'(rvalid3), 32'h4);
            chk("lat3_rdata",  32'(rdata3),  32'(rr_sbox[k]));
            tick();
        end
        #1;
        chk("lat3_done_rvalid", 32'(rvalid3), 32'h0);
        chk("lat3_done_rdata",  32'(rdata3),  32'h0);

        // Reset with two lookups in flight; pointer would otherwise favour requester 3.
        req3 = 4'b0100; addr3[23:16] = 8'h01;
        tick();
        tick();
        rst = 1'b1; req3 = 4'b1010;
        #1;
        chk("mid_rst_gnt", 32'(gnt3), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_gnt",    32'(gnt3),    32'h2);
        chk("post_rst_rvalid", 32'(rvalid3), 32'h0);
        tick();
        req3 = '0;
        #1;
        chk("flush_rvalid_a", 32'(rvalid3), 32'h0);
        tick();
        #1;
        chk("flush_rvalid_b", 32'(rvalid3), 32'h0);
        tick();
        #1;
        chk("post_rst_result", 32'(rvalid3), 32'h2);

`ifdef SBOX_ARB_LOCK_EN
        // Burst locking: requester 0 holds the port while locked.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req1 = 4'b0011; lock1 = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("lock_gnt", 32'(gnt1), 32'h1);
            tick();
        end
        lock1 = '0;
        #1;
        chk("unlock_gnt", 32'(gnt1), 32'h2);
        tick();
        req1 = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
